pkt_job_sched: RTL and testbench
================================

Name: pkt_job_sched

Overview:
Scheduler that sequences the packet builder (PB) and packet parser (PP) register ports as one build-then-parse job.
- Accepts jobs from a requester through a small FIFO.
- Drives PB start/config and waits for the PB interrupt.
- Then points PP at the built packet and waits for the PP interrupt.
- Returns a per-job status record (error flags and a byte-count/type mismatch check) through a valid/ready result port.
- Sits between the top-level register block and the pb/pp register interfaces.

Parameters:
- FIFO_DEPTH, 4, job FIFO entries; power of two, ≥ 2.
- TIMEOUT_CYC, 1024, watchdog limit per wait state (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  FIFO not full
- job_addr_in  in  32  PB source address
- job_addr_out  in  32  PB destination address; also PP header address
- job_byte_cnt  in  4  payload bytes minus 1
- job_pkt_type  in  4  packet type
- job_ecc_en, job_crc_en  in  1 each  PB protection enables
- job_ins_ecc_err, job_ins_crc_err  in  1 each  PB error injection
- job_ignore_ecc_err  in  1  forwarded to PP
- pb_start  out  1  one-cycle start pulse
- pb_busy, pb_irq  in  1 each  PB status, PB done pulse
- pb_addr_in, pb_addr_out  out  32 each
- pb_byte_cnt, pb_pkt_type  out  4 each
- pb_ecc_en, pb_crc_en, pb_ins_ecc_err, pb_ins_crc_err  out  1 each
- pp_start  out  1  one-cycle start pulse
- pp_busy, pp_irq  in  1 each
- pp_addr_hdr  out  32
- pp_ignore_ecc_err  out  1
- pp_pkt_ecc_corr, pp_pkt_ecc_uncorr, pp_pkt_crc_err  in  1 each
- pp_pkt_byte_cnt, pp_pkt_type  in  4 each
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_status  out  6  {timeout, mismatch, crc_err, ecc_uncorr, ecc_corr, ok}
- sched_busy  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset values:
  - All outputs are 0.
  - FIFO is empty; FSM is in IDLE.
  - A reset mid-job abandons the job with no result.
  - PB/PP are not notified.
- FIFO:
  - A push occurs when job_valid && job_ready. Pointers wrap mod FIFO_DEPTH.
  - job_ready = !full, so a full FIFO blocks the push even if a pop happens the same cycle.
  - FSM pops only in IDLE, when the FIFO is non-empty and res_valid == 0.
  - Simultaneous push and pop are allowed when the FIFO is not full.
  - Popping into the current-job register takes 1 cycle.
- FSM states:
  - IDLE: pop a job into the current-job register, then go to PB_ARM.
  - PB_ARM: PB config outputs are driven from the job register from this state until PP_ARM. When pb_busy == 0, assert pb_start for exactly 1 cycle and go to PB_WAIT. If pb_busy == 1, hold without pulsing.
  - PB_WAIT: on pb_irq, go to PP_ARM. A pb_irq in any other state is ignored.
  - PP_ARM: drive pp_addr_hdr = job_addr_out and pp_ignore_ecc_err. When pp_busy == 0, pulse pp_start for 1 cycle and go to PP_WAIT.
  - PP_WAIT: on pp_irq, capture the PP status inputs in that same cycle and go to REPORT.
  - REPORT: res_valid = 1 and res_status is held stable until res_ready, then go to IDLE.
- Status encoding:
  - mismatch = (pp_pkt_byte_cnt != job_byte_cnt) || (pp_pkt_type != job_pkt_type).
  - ok = none of the other five bits set.
- Latency:
  - Job accept to pb_start: minimum 3 cycles (push, pop, arm).
  - pp_irq to res_valid: 1 cycle.
- pb_start and pp_start are never asserted in the same cycle, and never twice per job.

Optional Feature:
- Macro JOB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to PB_WAIT and PP_WAIT and increments each cycle in those states.
  - When it reaches TIMEOUT_CYC - 1, the FSM goes to REPORT with timeout = 1 and all other status bits 0.
  - An irq arriving in the same cycle as the timeout wins (normal capture, timeout = 0).
- When undefined: no counter is present, the FSM waits indefinitely, and the timeout bit is tied to 0.

Decomposition:
- Package pkt_sched_pkg holds:
  - job_t struct: addr_in, addr_out, byte_cnt, pkt_type, and the 5 flag bits.
  - sched_state_e enum: IDLE, PB_ARM, PB_WAIT, PP_ARM, PP_WAIT, REPORT.
  - Status bit index constants.
- Natural sub-module: pkt_job_fifo, parameterised by FIFO_DEPTH, storing job_t.

Test Plan:
- Single job (addr_in = 0x100, addr_out = 0x200, byte_cnt = 7, type = 2, pb/pp never busy, PP echoes cnt = 7, type = 2):
  - pb_start pulses once; after pb_irq, pp_start pulses with pp_addr_hdr = 0x200.
  - res_status = 6'b000001.
- PB busy: pb_busy held high for 10 cycles in PB_ARM → pb_start is withheld until the first cycle with pb_busy low, then pulses exactly once.
- PP reports ecc_uncorr = 1 and byte_cnt = 6 versus job 7 → res_status = 6'b010100. Holding res_ready low for 5 cycles keeps res_valid and res_status stable, and no new job is popped.
- Back-pressure: push 5 jobs with FIFO_DEPTH = 4 while the FSM is blocked → job_ready drops after 4. All jobs complete in order; a scoreboard checks each pb_addr_in.
- Reset asserted in PP_WAIT → next cycle all outputs are 0 and FIFO is empty. A later stale pp_irq produces no result.
- With JOB_TIMEOUT_EN and TIMEOUT_CYC = 16, no pb_irq → res_status = 6'b100000 on the cycle after 16 PB_WAIT cycles.

Source files
------------

// File: rtl/pkt_sched_pkg.sv
// Shared types and constants for the PB/PP build-then-parse job scheduler.
package pkt_sched_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned STATUS_W = 6;

    localparam int unsigned ST_OK         = 0;
    localparam int unsigned ST_ECC_CORR   = 1;
    localparam int unsigned ST_ECC_UNCORR = 2;
    localparam int unsigned ST_CRC_ERR    = 3;
    localparam int unsigned ST_MISMATCH   = 4;
    localparam int unsigned ST_TIMEOUT    = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr_in;
        logic [ADDR_W-1:0] addr_out;
        logic [CNT_W-1:0]  byte_cnt;
        logic [CNT_W-1:0]  pkt_type;
        logic              ecc_en;
        logic              crc_en;
        logic              ins_ecc_err;
        logic              ins_crc_err;
        logic              ignore_ecc_err;
    } job_t;

    typedef enum logic [2:0] {
        IDLE,
        PB_ARM,
        PB_WAIT,
        PP_ARM,
        PP_WAIT,
        REPORT
    } sched_state_e;

    // ok is set only when no other status bit is set.
    function automatic logic [STATUS_W-1:0] make_status(
        input logic timeout,
        input logic mismatch,
        input logic crc_err,
        input logic ecc_uncorr,
        input logic ecc_corr
    );
        logic [STATUS_W-1:0] s;
        s                = '0;
        s[ST_TIMEOUT]    = timeout;
        s[ST_MISMATCH]   = mismatch;
        s[ST_CRC_ERR]    = crc_err;
        s[ST_ECC_UNCORR] = ecc_uncorr;
        s[ST_ECC_CORR]   = ecc_corr;
        s[ST_OK]         = !(timeout || mismatch || crc_err || ecc_uncorr || ecc_corr);
        return s;
    endfunction

endpackage

// File: rtl/pkt_job_fifo.sv
// Job FIFO for the scheduler; ready is registered and low while held in reset.
module pkt_job_fifo
    import pkt_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  job_t data_in,
    input  logic pop,
    output job_t data_out,
    output logic ready,
    output logic empty,
    output logic busy_nxt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    job_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_nxt;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign push_ok   = push && ready;
    assign pop_ok    = pop && !empty;
    assign level_nxt = level + LVL_W'(push_ok) - LVL_W'(pop_ok);
    assign empty     = (level == '0);
    assign busy_nxt  = (level_nxt != '0);
    assign data_out  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level_nxt;
            ready <= (level_nxt != LVL_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/pkt_job_sched.sv
// Sequences one PB build then one PP parse per queued job and reports a status record.
// Define JOB_TIMEOUT_EN to add a per-wait-state watchdog of TIMEOUT_CYC cycles.
module pkt_job_sched
    import pkt_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
`ifdef JOB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_addr_in,
    input  logic [31:0] job_addr_out,
    input  logic [3:0]  job_byte_cnt,
    input  logic [3:0]  job_pkt_type,
    input  logic        job_ecc_en,
    input  logic        job_crc_en,
    input  logic        job_ins_ecc_err,
    input  logic        job_ins_crc_err,
    input  logic        job_ignore_ecc_err,
    output logic        pb_start,
    input  logic        pb_busy,
    input  logic        pb_irq,
    output logic [31:0] pb_addr_in,
    output logic [31:0] pb_addr_out,
    output logic [3:0]  pb_byte_cnt,
    output logic [3:0]  pb_pkt_type,
    output logic        pb_ecc_en,
    output logic        pb_crc_en,
    output logic        pb_ins_ecc_err,
    output logic        pb_ins_crc_err,
    output logic        pp_start,
    input  logic        pp_busy,
    input  logic        pp_irq,
    output logic [31:0] pp_addr_hdr,
    output logic        pp_ignore_ecc_err,
    input  logic        pp_pkt_ecc_corr,
    input  logic        pp_pkt_ecc_uncorr,
    input  logic        pp_pkt_crc_err,
    input  logic [3:0]  pp_pkt_byte_cnt,
    input  logic [3:0]  pp_pkt_type,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [5:0]  res_status,
    output logic        sched_busy
);

    sched_state_e      state;
    job_t              in_job;
    job_t              head_job;
    logic              fifo_empty;
    logic              fifo_busy_nxt;
    logic              pop;
    logic              mismatch;
    logic              tmo_hit;
    logic [ADDR_W-1:0] cur_addr_out;
    logic [CNT_W-1:0]  cur_byte_cnt;
    logic [CNT_W-1:0]  cur_pkt_type;
    logic              cur_ignore;

    assign in_job = '{
        addr_in:        job_addr_in,
        addr_out:       job_addr_out,
        byte_cnt:       job_byte_cnt,
        pkt_type:       job_pkt_type,
        ecc_en:         job_ecc_en,
        crc_en:         job_crc_en,
        ins_ecc_err:    job_ins_ecc_err,
        ins_crc_err:    job_ins_crc_err,
        ignore_ecc_err: job_ignore_ecc_err
    };

    pkt_job_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (job_valid),
        .data_in  (in_job),
        .pop      (pop),
        .data_out (head_job),
        .ready    (job_ready),
        .empty    (fifo_empty),
        .busy_nxt (fifo_busy_nxt)
    );

    assign pop      = (state == IDLE) && !fifo_empty && !res_valid;
    assign mismatch = (pp_pkt_byte_cnt != cur_byte_cnt) || (pp_pkt_type != cur_pkt_type);

`ifdef JOB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYC - 1));

    // Cleared on the arming edge so it reads 0 in the first wait cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if ((state == PB_ARM && !pb_busy) || (state == PP_ARM && !pp_busy)) begin
            tmo_cnt <= '0;
        end else if (state == PB_WAIT || state == PP_WAIT) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cur_addr_out      <= '0;
            cur_byte_cnt      <= '0;
            cur_pkt_type      <= '0;
            cur_ignore        <= 1'b0;
            pb_start          <= 1'b0;
            pb_addr_in        <= '0;
            pb_addr_out       <= '0;
            pb_byte_cnt       <= '0;
            pb_pkt_type       <= '0;
            pb_ecc_en         <= 1'b0;
            pb_crc_en         <= 1'b0;
            pb_ins_ecc_err    <= 1'b0;
            pb_ins_crc_err    <= 1'b0;
            pp_start          <= 1'b0;
            pp_addr_hdr       <= '0;
            pp_ignore_ecc_err <= 1'b0;
            res_valid         <= 1'b0;
            res_status        <= '0;
        end else begin
            pb_start <= 1'b0;
            pp_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_addr_out   <= head_job.addr_out;
                        cur_byte_cnt   <= head_job.byte_cnt;
                        cur_pkt_type   <= head_job.pkt_type;
                        cur_ignore     <= head_job.ignore_ecc_err;
                        pb_addr_in     <= head_job.addr_in;
                        pb_addr_out    <= head_job.addr_out;
                        pb_byte_cnt    <= head_job.byte_cnt;
                        pb_pkt_type    <= head_job.pkt_type;
                        pb_ecc_en      <= head_job.ecc_en;
                        pb_crc_en      <= head_job.crc_en;
                        pb_ins_ecc_err <= head_job.ins_ecc_err;
                        pb_ins_crc_err <= head_job.ins_crc_err;
                        state          <= PB_ARM;
                    end
                end
                PB_ARM: begin
                    if (!pb_busy) begin
                        pb_start <= 1'b1;
                        state    <= PB_WAIT;
                    end
                end
                PB_WAIT: begin
                    if (pb_irq || tmo_hit) begin
                        pb_addr_in     <= '0;
                        pb_addr_out    <= '0;
                        pb_byte_cnt    <= '0;
                        pb_pkt_type    <= '0;
                        pb_ecc_en      <= 1'b0;
                        pb_crc_en      <= 1'b0;
                        pb_ins_ecc_err <= 1'b0;
                        pb_ins_crc_err <= 1'b0;
                    end
                    if (pb_irq) begin
                        pp_addr_hdr       <= cur_addr_out;
                        pp_ignore_ecc_err <= cur_ignore;
                        state             <= PP_ARM;
                    end else if (tmo_hit) begin
                        res_valid  <= 1'b1;
                        res_status <= make_status(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                        state      <= REPORT;
                    end
                end
                PP_ARM: begin
                    if (!pp_busy) begin
                        pp_start <= 1'b1;
                        state    <= PP_WAIT;
                    end
                end
                PP_WAIT: begin
                    // A completion in the watchdog's final cycle is reported normally.
                    if (pp_irq || tmo_hit) begin
                        pp_addr_hdr       <= '0;
                        pp_ignore_ecc_err <= 1'b0;
                        res_valid         <= 1'b1;
                        state             <= REPORT;
                    end
                    if (pp_irq) begin
                        res_status <= make_status(1'b0, mismatch, pp_pkt_crc_err,
                                                  pp_pkt_ecc_uncorr, pp_pkt_ecc_corr);
                    end else if (tmo_hit) begin
                        res_status <= make_status(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        res_status <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tracks the post-edge state so it matches the FSM and FIFO contents each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sched_busy <= 1'b0;
        end else begin
            sched_busy <= pop || fifo_busy_nxt ||
                          ((state != IDLE) && !(state == REPORT && res_ready));
        end
    end

endmodule

// File: tb/tb_pkt_job_sched.sv
// Directed bench for pkt_job_sched: single job, PB busy, error status/hold, back-pressure, reset, timeout.
`timescale 1ns/1ps
module tb_pkt_job_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_addr_in;
    logic [31:0] job_addr_out;
    logic [3:0]  job_byte_cnt;
    logic [3:0]  job_pkt_type;
    logic        job_ecc_en;
    logic        job_crc_en;
    logic        job_ins_ecc_err;
    logic        job_ins_crc_err;
    logic        job_ignore_ecc_err;
    logic        pb_start;
    logic        pb_busy;
    logic        pb_irq;
    logic [31:0] pb_addr_in;
    logic [31:0] pb_addr_out;
    logic [3:0]  pb_byte_cnt;
    logic [3:0]  pb_pkt_type;
    logic        pb_ecc_en;
    logic        pb_crc_en;
    logic        pb_ins_ecc_err;
    logic        pb_ins_crc_err;
    logic        pp_start;
    logic        pp_busy;
    logic        pp_irq;
    logic [31:0] pp_addr_hdr;
    logic        pp_ignore_ecc_err;
    logic        pp_pkt_ecc_corr;
    logic        pp_pkt_ecc_uncorr;
    logic        pp_pkt_crc_err;
    logic [3:0]  pp_pkt_byte_cnt;
    logic [3:0]  pp_pkt_type;
    logic        res_valid;
    logic        res_ready;
    logic [5:0]  res_status;
    logic        sched_busy;

    int          total = 0;
    int          bad = 0;
    int          pb_starts = 0;
    int          pp_starts = 0;
    int          handled_pb = 0;
    int          handled_pp = 0;
    int          lat;
    logic        overlap = 1'b0;
    logic [31:0] pb_log[$];
    logic [31:0] exp_q[$];

    pkt_job_sched #(
        .FIFO_DEPTH(4)
`ifdef JOB_TIMEOUT_EN
        , .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .job_valid          (job_valid),
        .job_ready          (job_ready),
        .job_addr_in        (job_addr_in),
        .job_addr_out       (job_addr_out),
        .job_byte_cnt       (job_byte_cnt),
        .job_pkt_type       (job_pkt_type),
        .job_ecc_en         (job_ecc_en),
        .job_crc_en         (job_crc_en),
        .job_ins_ecc_err    (job_ins_ecc_err),
        .job_ins_crc_err    (job_ins_crc_err),
        .job_ignore_ecc_err (job_ignore_ecc_err),
        .pb_start           (pb_start),
        .pb_busy            (pb_busy),
        .pb_irq             (pb_irq),
        .pb_addr_in         (pb_addr_in),
        .pb_addr_out        (pb_addr_out),
        .pb_byte_cnt        (pb_byte_cnt),
        .pb_pkt_type        (pb_pkt_type),
        .pb_ecc_en          (pb_ecc_en),
        .pb_crc_en          (pb_crc_en),
        .pb_ins_ecc_err     (pb_ins_ecc_err),
        .pb_ins_crc_err     (pb_ins_crc_err),
        .pp_start           (pp_start),
        .pp_busy            (pp_busy),
        .pp_irq             (pp_irq),
        .pp_addr_hdr        (pp_addr_hdr),
        .pp_ignore_ecc_err  (pp_ignore_ecc_err),
        .pp_pkt_ecc_corr    (pp_pkt_ecc_corr),
        .pp_pkt_ecc_uncorr  (pp_pkt_ecc_uncorr),
        .pp_pkt_crc_err     (pp_pkt_crc_err),
        .pp_pkt_byte_cnt    (pp_pkt_byte_cnt),
        .pp_pkt_type        (pp_pkt_type),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_status         (res_status),
        .sched_busy         (sched_busy)
    );

    always #5 clk = ~clk;

    // Start-pulse monitor feeding the in-order scoreboard.
    always @(negedge clk) begin
        if (pb_start) begin
            pb_starts++;
            pb_log.push_back(pb_addr_in);
        end
        if (pp_start) pp_starts++;
        if (pb_start && pp_start) overlap = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [31:0] ai, input logic [31:0] ao,
                            input logic [3:0] bc, input logic [3:0] pt, input logic [4:0] fl);
        int n;
        job_addr_in        = ai;
        job_addr_out       = ao;
        job_byte_cnt       = bc;
        job_pkt_type       = pt;
        {job_ecc_en, job_crc_en, job_ins_ecc_err, job_ins_crc_err, job_ignore_ecc_err} = fl;
        job_valid          = 1'b1;
        n = 0;
        while (!job_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready", 32'(job_ready), 32'd1);
        tick();
        job_valid = 1'b0;
        exp_q.push_back(ai);
    endtask

    task automatic wait_pb(output int n);
        n = 0;
        while (!(pb_start || pb_starts > handled_pb) && n < 60) begin
            tick();
            n++;
        end
        chk("pb_start_seen", 32'(pb_start || pb_starts > handled_pb), 32'd1);
        handled_pb++;
    endtask

    task automatic wait_pp(output int n);
        n = 0;
        while (!(pp_start || pp_starts > handled_pp) && n < 60) begin
            tick();
            n++;
        end
        chk("pp_start_seen", 32'(pp_start || pp_starts > handled_pp), 32'd1);
        handled_pp++;
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_drop", 32'(res_valid), 32'd0);
    endtask

    // From PB_WAIT: PB done, PP armed and answered, result checked.
    task automatic finish_job(input logic [3:0] cnt, input logic [3:0] typ,
                              input logic corr, input logic uncorr, input logic crc,
                              input logic [31:0] hdr, input logic ign,
                              input logic [5:0] st, input logic rel);
        int n;
        pb_irq = 1'b1;
        tick();
        pb_irq = 1'b0;
        wait_pp(n);
        chk("pp_hdr", pp_addr_hdr, hdr);
        chk("pp_ignore", 32'(pp_ignore_ecc_err), 32'(ign));
        pp_pkt_byte_cnt   = cnt;
        pp_pkt_type       = typ;
        pp_pkt_ecc_corr   = corr;
        pp_pkt_ecc_uncorr = uncorr;
        pp_pkt_crc_err    = crc;
        pp_irq            = 1'b1;
        tick();
        pp_irq            = 1'b0;
        pp_pkt_byte_cnt   = '0;
        pp_pkt_type       = '0;
        pp_pkt_ecc_corr   = 1'b0;
        pp_pkt_ecc_uncorr = 1'b0;
        pp_pkt_crc_err    = 1'b0;
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_status", 32'(res_status), 32'(st));
        if (rel) release_res();
    endtask

    logic [3:0]  bp_typ [5] = '{4'd1, 4'd1, 4'd2, 4'd1, 4'd1};
    logic        bp_corr[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        bp_crc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [5:0]  bp_st  [5] = '{6'b000001, 6'b001010, 6'b010000, 6'b000001, 6'b000001};

    initial begin
        logic        stable;
        logic        accepted;
        int          starts_before;

        reset = 1'b1;
        job_valid = 1'b0; job_addr_in = '0; job_addr_out = '0; job_byte_cnt = '0; job_pkt_type = '0;
        job_ecc_en = 1'b0; job_crc_en = 1'b0; job_ins_ecc_err = 1'b0; job_ins_crc_err = 1'b0;
        job_ignore_ecc_err = 1'b0;
        pb_busy = 1'b0; pb_irq = 1'b0; pp_busy = 1'b0; pp_irq = 1'b0;
        pp_pkt_ecc_corr = 1'b0; pp_pkt_ecc_uncorr = 1'b0; pp_pkt_crc_err = 1'b0;
        pp_pkt_byte_cnt = '0; pp_pkt_type = '0; res_ready = 1'b0;
        repeat (3) tick();

        chk("rst_job_ready", 32'(job_ready), 32'd0);
        chk("rst_sched_busy", 32'(sched_busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_status", 32'(res_status), 32'd0);
        chk("rst_starts", 32'({pb_start, pp_start}), 32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 32'(job_ready), 32'd1);

        // Single job, PP echoes count and type.
        push_job(32'h100, 32'h200, 4'd7, 4'd2, 5'b10101);
        wait_pb(lat);
        chk("lat_pb_start", 32'(lat), 32'd2);
        chk("pb_addr_in", pb_addr_in, 32'h100);
        chk("pb_addr_out", pb_addr_out, 32'h200);
        chk("pb_cnt_type", 32'({pb_byte_cnt, pb_pkt_type}), 32'h72);
        chk("pb_flags", 32'({pb_ecc_en, pb_crc_en, pb_ins_ecc_err, pb_ins_crc_err}), 32'b1010);
        chk("busy_in_job", 32'(sched_busy), 32'd1);
        finish_job(4'd7, 4'd2, 1'b0, 1'b0, 1'b0, 32'h200, 1'b1, 6'b000001, 1'b1);
        chk("pb_once", 32'(pb_starts), 32'd1);
        chk("pp_once", 32'(pp_starts), 32'd1);
        chk("idle_not_busy", 32'(sched_busy), 32'd0);

        // PB busy withholds the start pulse.
        pb_busy = 1'b1;
        push_job(32'h300, 32'h400, 4'd3, 4'd1, 5'b00000);
        stable = 1'b1;
        repeat (11) begin
            tick();
            if (pb_start) stable = 1'b0;
        end
        chk("busy_no_start", 32'(stable), 32'd1);
        pb_busy = 1'b0;
        tick();
        chk("busy_release_start", 32'(pb_start), 32'd1);
        handled_pb++;
        tick();
        chk("busy_single_pulse", 32'(pb_start), 32'd0);
        finish_job(4'd3, 4'd1, 1'b0, 1'b0, 1'b0, 32'h400, 1'b0, 6'b000001, 1'b1);
        chk("busy_pb_count", 32'(pb_starts), 32'd2);

        // Uncorrectable ECC plus count mismatch; result held while res_ready low.
        push_job(32'h500, 32'h600, 4'd7, 4'd5, 5'b00000);
        wait_pb(lat);
        finish_job(4'd6, 4'd5, 1'b0, 1'b1, 1'b0, 32'h600, 1'b0, 6'b010100, 1'b0);
        push_job(32'h700, 32'h800, 4'd2, 4'd3, 5'b00000);
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (!res_valid || res_status != 6'b010100 || pb_start || pb_addr_in != 32'h0)
                stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        chk("hold_no_pop", 32'(pb_starts), 32'd3);
        release_res();
        wait_pb(lat);
        chk("after_hold_addr", pb_addr_in, 32'h700);
        finish_job(4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 32'h800, 1'b0, 6'b000001, 1'b1);

        // Back-pressure: FSM parked in REPORT while the FIFO fills.
        push_job(32'hA0, 32'hA4, 4'd3, 4'd1, 5'b00000);
        wait_pb(lat);
        finish_job(4'd3, 4'd1, 1'b0, 1'b0, 1'b0, 32'hA4, 1'b0, 6'b000001, 1'b0);
        for (int i = 0; i < 4; i++)
            push_job(32'hB0 + 32'(i * 16), 32'hB4 + 32'(i * 16), 4'd3, 4'd1, 5'b00000);
        chk("bp_full", 32'(job_ready), 32'd0);
        job_addr_in = 32'hF0; job_addr_out = 32'hF4; job_byte_cnt = 4'd3; job_pkt_type = 4'd1;
        job_valid = 1'b1;
        repeat (3) tick();
        chk("bp_blocked", 32'(job_ready), 32'd0);
        chk("bp_res_held", 32'(res_valid), 32'd1);
        release_res();
        accepted = 1'b0;
        for (int k = 0; k < 20 && !accepted; k++) begin
            if (job_ready) begin
                tick();
                job_valid = 1'b0;
                accepted = 1'b1;
            end else begin
                tick();
            end
        end
        job_valid = 1'b0;
        chk("bp_accept", 32'(accepted), 32'd1);
        exp_q.push_back(32'hF0);
        for (int j = 0; j < 5; j++) begin
            wait_pb(lat);
            finish_job(4'd3, bp_typ[j], bp_corr[j], 1'b0, bp_crc[j], 32'hB4 + 32'(j * 16),
                       1'b0, bp_st[j], 1'b1);
        end

        // Reset while parked in PP_WAIT with another job queued.
        push_job(32'hC00, 32'hD00, 4'd4, 4'd4, 5'b00001);
        wait_pb(lat);
        pb_irq = 1'b1;
        tick();
        pb_irq = 1'b0;
        wait_pp(lat);
        push_job(32'hE00, 32'hE80, 4'd4, 4'd4, 5'b00000);
        void'(exp_q.pop_back());
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_res", 32'({res_valid, res_status}), 32'd0);
        chk("mid_rst_pp", pp_addr_hdr, 32'd0);
        chk("mid_rst_pb", pb_addr_in, 32'd0);
        chk("mid_rst_misc", 32'({job_ready, sched_busy, pp_ignore_ecc_err, pb_start, pp_start}), 32'd0);
        tick();
        chk("rst_fifo_empty", 32'(sched_busy), 32'd0);
        starts_before = pb_starts;
        pp_pkt_byte_cnt = 4'd4; pp_pkt_type = 4'd4; pp_irq = 1'b1;
        tick();
        pp_irq = 1'b0; pp_pkt_byte_cnt = '0; pp_pkt_type = '0;
        repeat (4) tick();
        chk("stale_irq_no_res", 32'(res_valid), 32'd0);
        chk("stale_no_start", 32'(pb_starts), 32'(starts_before));
        push_job(32'h1000, 32'h2000, 4'd1, 4'd9, 5'b00000);
        wait_pb(lat);
        finish_job(4'd1, 4'd9, 1'b0, 1'b0, 1'b0, 32'h2000, 1'b0, 6'b000001, 1'b1);

`ifdef JOB_TIMEOUT_EN
        // Watchdog: no PB completion.
        push_job(32'h3000, 32'h4000, 4'd1, 4'd1, 5'b00000);
        wait_pb(lat);
        repeat (15) tick();
        chk("tmo_not_yet", 32'(res_valid), 32'd0);
        tick();
        chk("tmo_valid", 32'(res_valid), 32'd1);
        chk("tmo_status", 32'(res_status), 32'b100000);
        release_res();
`endif

        chk("sb_count", 32'(pb_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < pb_log.size(); i++)
            chk("sb_addr_in", pb_log[i], exp_q[i]);
        chk("no_start_overlap", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
